// File: rtl/rst_sequencer_if.sv
// Bundle between the reset sequencer and its environment.
// The sequencer drives the slave side and returns the sequenced resets.
interface rst_sequencer_if #(
    parameter int N_CH = 3
);
    logic            locked;
    logic            soft_rst_req;
    logic [N_CH-1:0] rst_out;
    logic            rst_done;
    logic [7:0]      lock_loss_cnt;

    modport master (
        output locked,
        output soft_rst_req,
        input  rst_out,
        input  rst_done,
        input  lock_loss_cnt
    );

    modport slave (
        input  locked,
        input  soft_rst_req,
        output rst_out,
        output rst_done,
        output lock_loss_cnt
    );
endinterface

// File: rtl/rst_sequencer.sv
// Lock-qualified, staggered release of N_CH reset channels.
// Restarts on lock loss (counted) or on a software request in RUN.
module rst_sequencer #(
    parameter int N_CH           = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_FILTER    = 4
) (
    input  logic          pclk,
    input  logic          rst,
    rst_sequencer_if.slave bus
);

    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(STAGGER_CYCLES + 1);
    localparam int IW = $clog2(N_CH + 1);

    typedef enum logic [2:0] {
        S_ASSERT,
        S_WAIT_LOCK,
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FW-1:0]          filt_q, filt_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [SW-1:0]          stag_q, stag_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [N_CH-1:0]        rst_out_q, rst_out_d;
    logic                   rst_done_q, rst_done_d;
    logic [7:0]             loss_q, loss_d;
    logic                   lock_s;
    logic                   restart;
    logic                   lost;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.locked};
        state_d    = state_q;
        filt_d     = '0;
        hold_d     = hold_q;
        stag_d     = stag_q;
        idx_d      = idx_q;
        rst_out_d  = rst_out_q;
        loss_d     = loss_q;
        restart    = 1'b0;
        lost       = 1'b0;
        rst_done_d = 1'b0;

        unique case (state_q)
            S_ASSERT: begin
                rst_out_d = '1;
                state_d   = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                rst_out_d = '1;
                if (lock_s) begin
                    if (filt_q == FW'(LOCK_FILTER - 1)) begin
                        state_d = S_HOLD;
                        // the qualifying cycle is the first hold cycle
                        hold_d  = HW'(1);
                    end else begin
                        filt_d = filt_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q >= HW'(HOLD_CYCLES - 1)) begin
                    rst_out_d[0] = 1'b0;
                    idx_d        = '0;
                    stag_d       = '0;
                    state_d      = (N_CH == 1) ? S_RUN : S_RELEASE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (stag_q == SW'(STAGGER_CYCLES - 1)) begin
                    stag_d = '0;
                    idx_d  = idx_q + 1'b1;
                    for (int k = 0; k < N_CH; k++) begin
                        if (k == int'(idx_q) + 1) begin
                            rst_out_d[k] = 1'b0;
                        end
                    end
                    if (int'(idx_q) + 1 >= N_CH - 1) begin
                        state_d = S_RUN;
                    end
                end else begin
                    stag_d = stag_q + 1'b1;
                end
            end
            S_RUN: begin
                rst_out_d = '0;
                if (bus.soft_rst_req) begin
                    restart = 1'b1;
                end
            end
            default: begin
                state_d = S_ASSERT;
            end
        endcase

        if (!lock_s && (state_q == S_HOLD ||
                        state_q == S_RELEASE ||
                        state_q == S_RUN)) begin
            restart = 1'b1;
            lost    = 1'b1;
        end

        // lock loss and soft request together are one restart
        if (restart) begin
            state_d   = S_ASSERT;
            rst_out_d = '1;
        end

        if (lost && loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
        end

        rst_done_d = (state_q == S_RUN) && (state_d == S_RUN);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q    <= S_ASSERT;
            sync_q     <= '0;
            filt_q     <= '0;
            hold_q     <= '0;
            stag_q     <= '0;
            idx_q      <= '0;
            rst_out_q  <= '1;
            rst_done_q <= 1'b0;
            loss_q     <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            hold_q     <= hold_d;
            stag_q     <= stag_d;
            idx_q      <= idx_d;
            rst_out_q  <= rst_out_d;
            rst_done_q <= rst_done_d;
            loss_q     <= loss_d;
        end
    end

    assign bus.rst_out       = rst_out_q;
    assign bus.rst_done      = rst_done_q;
    assign bus.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes with their
// cycle; the monitor pops one entry on every observed output change.
module tb_rst_sequencer;

    logic pclk;
    logic rst;
    int   cyc;
    int   vectors;
    int   errors;

    typedef struct {
        int         c;
        logic [2:0] ro;
        logic       rd;
        logic [7:0] cnt;
    } ev_t;

    ev_t exp_q[$];

    rst_sequencer_if #(.N_CH(3)) bus_if ();

    rst_sequencer #(
        .N_CH          (3),
        .HOLD_CYCLES   (16),
        .STAGGER_CYCLES(8),
        .SYNC_STAGES   (2),
        .LOCK_FILTER   (4)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [2:0] ro,
                        input logic rd, input logic [7:0] cnt);
        ev_t e;
        e.c   = c;
        e.ro  = ro;
        e.rd  = rd;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // locked (or rst release with locked high) driven in cycle n,
    // with the FSM waiting for lock when lock_s first rises at n+2
    task automatic expect_seq(input int n, input logic [7:0] cnt);
        push(n + 21, 3'b110, 1'b0, cnt);
        push(n + 29, 3'b100, 1'b0, cnt);
        push(n + 37, 3'b000, 1'b0, cnt);
        push(n + 38, 3'b000, 1'b1, cnt);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge pclk);
            #1;
        end
    endtask

    logic [11:0] prev;
    logic [11:0] cur;

    always @(negedge pclk) begin
        cur = {bus_if.rst_out, bus_if.rst_done, bus_if.lock_loss_cnt};
        if (cyc == 1 || (cyc > 1 && cur !== prev)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got ro=%b rd=%b cnt=%0d, none expected",
                         cyc, cur[11:9], cur[8], cur[7:0]);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.c != cyc || cur[11:9] !== e.ro ||
                    cur[8] !== e.rd || cur[7:0] !== e.cnt) begin
                    errors++;
                    $display("FAIL output_change got cyc=%0d ro=%b rd=%b cnt=%0d, need cyc=%0d ro=%b rd=%b cnt=%0d",
                             cyc, cur[11:9], cur[8], cur[7:0],
                             e.c, e.ro, e.rd, e.cnt);
                end
            end
        end
        prev = cur;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d, bench did not finish", cyc);
        $fatal(1, "watchdog");
    end

    int n;
    int ecnt;

    initial begin
        vectors = 0;
        errors  = 0;
        rst                 = 1'b1;
        bus_if.locked       = 1'b0;
        bus_if.soft_rst_req = 1'b0;
        push(1, 3'b111, 1'b0, 8'd0);

        // power-up: rst released with locked already high
        goto(3);
        rst           = 1'b0;
        bus_if.locked = 1'b1;
        expect_seq(3, 8'd0);

        // soft reset in RUN, then a soft pulse during HOLD is ignored
        goto(50);
        bus_if.soft_rst_req = 1'b1;
        push(51, 3'b111, 1'b0, 8'd0);
        expect_seq(50, 8'd0);
        goto(51);
        bus_if.soft_rst_req = 1'b0;
        goto(60);
        bus_if.soft_rst_req = 1'b1;
        goto(61);
        bus_if.soft_rst_req = 1'b0;

        // lock loss during RELEASE after channel 0 fell
        goto(100);
        bus_if.soft_rst_req = 1'b1;
        push(101, 3'b111, 1'b0, 8'd0);
        push(121, 3'b110, 1'b0, 8'd0);
        goto(101);
        bus_if.soft_rst_req = 1'b0;
        goto(124);
        bus_if.locked = 1'b0;
        push(127, 3'b111, 1'b0, 8'd1);

        // lock glitch while waiting: filter must restart
        goto(130);
        bus_if.locked = 1'b1;
        goto(133);
        bus_if.locked = 1'b0;
        goto(134);
        bus_if.locked = 1'b1;
        expect_seq(134, 8'd1);

        // lock loss and soft request in the same RUN cycle
        goto(180);
        bus_if.locked = 1'b0;
        goto(182);
        bus_if.soft_rst_req = 1'b1;
        push(183, 3'b111, 1'b0, 8'd2);
        goto(183);
        bus_if.soft_rst_req = 1'b0;

        // 300 further lock losses, each caught in HOLD
        ecnt = 2;
        for (int i = 0; i < 300; i++) begin
            n = 186 + 6 * i;
            goto(n);
            bus_if.locked = 1'b1;
            if (ecnt < 255) begin
                ecnt++;
                push(n + 7, 3'b111, 1'b0, 8'(ecnt));
            end
            goto(n + 4);
            bus_if.locked = 1'b0;
        end

        // back to RUN, then a one-cycle rst pulse
        goto(1995);
        bus_if.locked = 1'b1;
        expect_seq(1995, 8'd255);
        goto(2040);
        rst = 1'b1;
        push(2041, 3'b111, 1'b0, 8'd0);
        goto(2041);
        rst = 1'b0;
        expect_seq(2041, 8'd0);

        goto(2090);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d left, need 0 (next at cyc %0d)",
                     exp_q.size(), exp_q[0].c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
